// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready handshakes on both sides.
//
// A word on d is accepted when load_valid && load_ready. It is then shifted out
// MSB first, one beat per accepted sout handshake. load_ready is also high during
// the transfer of a frame's last beat, so a new word can follow with no idle
// bubble.
//
// Optional feature: define SERIAL_PARITY_EN to append one even-parity beat
// (XOR of the SIZE data bits) after the data beats. sout_last then marks the
// parity beat instead of the final data beat.
//
// Ports:
//   clk         clock, rising edge
//   clr_n       asynchronous active-low reset
//   load_valid  producer offers d
//   load_ready  block accepts a word this cycle
//   d           parallel word, SIZE bits
//   sout        current serial bit
//   sout_valid  sout holds a valid beat
//   sout_ready  consumer accepts the current beat
//   sout_last   current beat is the last of the frame
//   busy        a frame is in progress
module piso_serializer #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [SIZE-1:0] d,
  output logic            sout,
  output logic            sout_valid,
  input  logic            sout_ready,
  output logic            sout_last,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(SIZE + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SIZE - 1);

`ifdef SERIAL_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e            state_q, state_d;
  logic [SIZE-1:0]   shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic beat;
  logic accept;
  logic last_data;

  assign last_data  = (cnt_q == LastCnt);
  assign sout_valid = (state_q != StIdle);
  assign busy       = (state_q != StIdle);
  assign beat       = sout_valid & sout_ready;
  // Ready in IDLE, or while the frame's last beat is actually transferring.
  assign load_ready = (state_q == StIdle) | (sout_last & sout_ready);
  assign accept     = load_valid & load_ready;

  // Output decode
  always_comb begin
    sout      = 1'b0;
    sout_last = 1'b0;
    unique case (state_q)
      StShift: begin
        sout = shift_q[SIZE-1];
`ifndef SERIAL_PARITY_EN
        sout_last = last_data;
`endif
      end
`ifdef SERIAL_PARITY_EN
      StParity: begin
        sout      = parity_q;
        sout_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: ;
      StShift: begin
        if (beat) begin
          shift_d = {shift_q[SIZE-2:0], 1'b0};
          cnt_d   = cnt_q + CntW'(1);
`ifdef SERIAL_PARITY_EN
          // Accumulate parity over the bits as they leave.
          parity_d = parity_q ^ shift_q[SIZE-1];
          if (last_data) state_d = StParity;
`else
          if (last_data) state_d = StIdle;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      StParity: begin
        if (beat) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    // A load overrides the end-of-frame return to IDLE (back-to-back frames).
    if (accept) begin
      state_d  = StShift;
      shift_d  = d;
      cnt_d    = '0;
`ifdef SERIAL_PARITY_EN
      parity_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      cnt_q    <= '0;
`ifdef SERIAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
